// File: rtl/wb_stage_pkg.sv
// Shared widths and types for the writeback stage: register file geometry,
// default load-queue depth and the registered write-port bundle.
package wb_stage_pkg;
  localparam int DATA_W       = 16;
  localparam int REG_AW       = 3;
  localparam int NUM_REGS     = 8;
  localparam int LQ_DEPTH_DEF = 2;

  typedef struct packed {
    logic              wr;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_wr_t;

  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_AW-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction
endpackage

// File: rtl/wb_stage_if.sv
// Execute/memory-return inputs and register-file/scoreboard outputs of the
// writeback stage. The master side drives execute and memory signals.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic                ex_vld;
  logic                ex_load;
  logic [REG_AW-1:0]   ex_rd;
  logic [DATA_W-1:0]   ex_data;
  logic                ex_stall;
  logic                mem_rvld;
  logic [DATA_W-1:0]   mem_rdata;
  logic                wr;
  logic [REG_AW-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [NUM_REGS-1:0] busy;
  logic                err;

  modport master (
    output ex_vld, ex_load, ex_rd, ex_data, mem_rvld, mem_rdata,
    input  ex_stall, wr, waddr, wdata, busy, err
  );

  modport slave (
    input  ex_vld, ex_load, ex_rd, ex_data, mem_rvld, mem_rdata,
    output ex_stall, wr, waddr, wdata, busy, err
  );
endinterface

// File: rtl/wb_stage_load_queue.sv
// In-order FIFO of destination tags for loads awaiting their memory return.
// Pointers wrap naturally because the depth is a power of two.
module wb_load_queue
  import wb_stage_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEF,
  localparam int PW = $clog2(LQ_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [REG_AW-1:0] i_tag,
  input  logic              i_pop,
  output logic [REG_AW-1:0] o_head,
  output logic [CW-1:0]     o_count,
  output logic              o_empty
);
  logic [REG_AW-1:0] r_mem [LQ_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_count == CW'(LQ_DEPTH));
  assign w_empty = (r_count == '0);
  // Guards keep the FIFO consistent even if a caller misbehaves.
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_tag;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = w_empty;
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: sole register-file writer, retiring ALU results and
// in-order load returns, with a per-register pending-load scoreboard.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  wb_wr_t              r_wb;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_err;

  logic [REG_AW-1:0]   w_head;
  logic [CW-1:0]       w_count;
  logic                w_empty, w_full;
  logic                w_stall, w_acc, w_push, w_pop;
  logic [NUM_REGS-1:0] w_set, w_clr;

  // Full is taken before any same-cycle pop, so a return never frees a slot early.
  assign w_full  = (w_count == CW'(LQ_DEPTH));
  assign w_stall = bus.ex_vld &
                   (r_busy[bus.ex_rd] | (bus.ex_load ? w_full : bus.mem_rvld));
  assign w_acc   = bus.ex_vld & ~w_stall;
  assign w_push  = w_acc & bus.ex_load;
  assign w_pop   = bus.mem_rvld & ~w_empty;
  assign w_set   = w_push ? reg_mask(bus.ex_rd) : '0;
  assign w_clr   = w_pop  ? reg_mask(w_head)    : '0;

  wb_load_queue #(.LQ_DEPTH(LQ_DEPTH)) u_lq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_tag   (bus.ex_rd),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb   <= '0;
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wb.wr <= 1'b0;
      // A return and an ALU accept are mutually exclusive via the stall.
      if (w_pop) begin
        r_wb <= '{wr: 1'b1, addr: w_head, data: bus.mem_rdata};
      end else if (w_acc & ~bus.ex_load) begin
        r_wb <= '{wr: 1'b1, addr: bus.ex_rd, data: bus.ex_data};
      end
      r_busy <= (r_busy | w_set) & ~w_clr;
      if (bus.mem_rvld & w_empty) r_err <= 1'b1;
    end
  end

  assign bus.ex_stall = w_stall;
  assign bus.wr       = r_wb.wr;
  assign bus.waddr    = r_wb.addr;
  assign bus.wdata    = r_wb.data;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
endmodule
